// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path
// and the ASCII-digit assembler.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 10417;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver: input synchroniser, framing FSM,
// received byte register with valid / framing-error pulses.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);

  logic sync1_q;
  logic sync2_q;
  logic rxd_s;

  rx_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  assign rxd_s = sync2_q;

  // Line idles high, so the synchroniser resets to 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          if (rxd_s) state_d = IDLE;
          else       state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxd_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_byte   = byte_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_rx_digits.sv
// UART receiver feeding four BCD digit registers for the
// seven-segment display, with per-byte status pulses.
module uart_rx_digits
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DIGITS       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rxd,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       bad_char,
  output logic       frame_done
);

  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  logic [3:0]    dig_q [DIGITS];
  logic [3:0]    dig_d [DIGITS];
  logic [IW-1:0] idx_q, idx_d;
  logic          bad_q, bad_d;
  logic          done_q, done_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (Rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  // CR restarts entry at digit0 without touching the display
  always_comb begin
    dig_d  = dig_q;
    idx_d  = idx_q;
    bad_d  = 1'b0;
    done_d = 1'b0;
    if (rx_valid) begin
      unique case (1'b1)
        is_digit(rx_byte): begin
          dig_d[idx_q] = rx_byte[3:0];
          if (idx_q == LAST) begin
            idx_d  = '0;
            done_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        (rx_byte == ASCII_CR): idx_d = '0;
        default:               bad_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_q  <= '{default: '0};
      idx_q  <= '0;
      bad_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dig_q  <= dig_d;
      idx_q  <= idx_d;
      bad_q  <= bad_d;
      done_q <= done_d;
    end
  end

  assign digit0     = dig_q[0];
  assign digit1     = dig_q[1];
  assign digit2     = dig_q[2];
  assign digit3     = dig_q[3];
  assign bad_char   = bad_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_rx_digits.sv
// Self-checking bench for uart_rx_digits at 16 clocks per bit.
module tb_uart_rx_digits;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Rxd = 1'b1;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [7:0] rx_byte;
  logic       rx_valid, frame_err, bad_char, frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] b;
    bit         ferr;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] rx_log[$];

  logic [3:0] m_dig [4];
  int         m_idx;
  logic [7:0] m_byte;
  bit         pend_bad, pend_done;
  int         n_bad, n_done, n_ferr;

  uart_rx_digits #(
    .CLKS_PER_BIT(CPB),
    .DIGITS      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Rxd       (Rxd),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .bad_char  (bad_char),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Byte-level model: what each framed byte must do
  always @(negedge clk) begin
    if (!rst) begin
      m_dig     = '{default: '0};
      m_idx     = 0;
      m_byte    = 8'h00;
      pend_bad  = 1'b0;
      pend_done = 1'b0;
      exp_q.delete();
    end else begin
      chk("digits", {digit3, digit2, digit1, digit0},
          {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
      chk("bad_char", bad_char, pend_bad);
      chk("frame_done", frame_done, pend_done);
      if (bad_char)   n_bad++;
      if (frame_done) n_done++;
      pend_bad  = 1'b0;
      pend_done = 1'b0;
      if (rx_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {rx_valid, frame_err}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {rx_valid, frame_err},
              e.ferr ? 2'b01 : 2'b10);
          if (frame_err) n_ferr++;
          if (rx_valid) begin
            chk("rx_byte", rx_byte, e.b);
            rx_log.push_back(rx_byte);
            m_byte = e.b;
            if (e.b >= 8'h30 && e.b <= 8'h39) begin
              m_dig[m_idx] = e.b[3:0];
              if (m_idx == 3) begin
                m_idx     = 0;
                pend_done = 1'b1;
              end else begin
                m_idx = m_idx + 1;
              end
            end else if (e.b == 8'h0D) begin
              m_idx = 0;
            end else begin
              pend_bad = 1'b1;
            end
          end
        end
      end else begin
        chk("rx_byte_hold", rx_byte, m_byte);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b,
                      input logic stop);
    exp_t x;
    x.b    = b;
    x.ferr = !stop;
    exp_q.push_back(x);
    Rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      Rxd = b[i];
      idle(CPB);
    end
    Rxd = stop;
    idle(CPB);
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_digits", {digit3, digit2, digit1, digit0}, 0);
    chk("rst_byte", rx_byte, 0);
    chk("rst_pulses",
        {rx_valid, frame_err, bad_char, frame_done}, 0);
    idle(3);
    rst = 1'b1;
    idle(10);

    // four digits
    send("1", 1'b1);
    send("2", 1'b1);
    send("3", 1'b1);
    send("4", 1'b1);
    idle(4);
    chk("four_digits", {digit3, digit2, digit1, digit0},
        16'h4321);
    chk("four_done", n_done, 1);
    chk("four_byte", rx_byte, 8'h34);

    // wrap then CR
    send("5", 1'b1);
    send("6", 1'b1);
    send(8'h0D, 1'b1);
    send("7", 1'b1);
    idle(4);
    chk("cr_digits", {digit3, digit2, digit1, digit0},
        16'h4367);
    chk("cr_done", n_done, 1);
    chk("cr_bad", n_bad, 0);

    // bad character
    send("A", 1'b1);
    idle(4);
    chk("bad_byte", rx_byte, 8'h41);
    chk("bad_count", n_bad, 1);
    chk("bad_digits", {digit3, digit2, digit1, digit0},
        16'h4367);

    // short glitch
    Rxd = 1'b0;
    idle(4);
    Rxd = 1'b1;
    idle(40);
    chk("glitch_log", rx_log.size(), 9);

    // framing error with line held low
    send(8'h35, 1'b0);
    idle(64);
    Rxd = 1'b1;
    idle(32);
    chk("ferr_count", n_ferr, 1);
    chk("ferr_byte", rx_byte, 8'h41);
    send("9", 1'b1);
    idle(4);
    chk("after_ferr", {digit3, digit2, digit1, digit0},
        16'h4397);

    // back-to-back frames
    send("8", 1'b1);
    send("9", 1'b1);
    idle(4);
    chk("b2b_count", rx_log.size(), 12);
    chk("b2b_first", rx_log[10], 8'h38);
    chk("b2b_second", rx_log[11], 8'h39);
    chk("b2b_ferr", n_ferr, 1);
    chk("b2b_digits", {digit3, digit2, digit1, digit0},
        16'h9897);

    // asynchronous reset in the middle of a byte
    Rxd = 1'b0;
    idle(40);
    #2 rst = 1'b0;
    #1;
    chk("arst_digits", {digit3, digit2, digit1, digit0}, 0);
    chk("arst_byte", rx_byte, 0);
    chk("arst_pulses",
        {rx_valid, frame_err, bad_char, frame_done}, 0);
    Rxd = 1'b1;
    idle(3);
    rst = 1'b1;
    idle(200);
    send("3", 1'b1);
    idle(4);
    chk("post_rst", {digit3, digit2, digit1, digit0},
        16'h0003);

    idle(50);
    chk("exp_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
